cache_miss_unit: RTL and testbench

Miss-handling stage sitting directly downstream of the cache tag/data table. On a lookup miss it takes the selected victim way, writes the victim line back to memory if it is valid and dirty, fetches the missing line as a burst and writes each returned word into the table's write port. It finishes by writing the tag, valid and dirty bits and signalling completion to the pipeline. It serves both the I-cache and D-cache; stores merge their data into the refilled line.

---
 rtl/cache_pkg.sv | 35 +++
 rtl/cache_miss_unit_beat_counter.sv | 42 ++++
 rtl/cache_miss_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_cache_miss_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss-handling path: FSM state encoding,
// memory-side request type codes and the store byte-merge helper.
package cache_pkg;

  // Miss-handling FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WB     = 3'd1,
    ST_RD     = 3'd2,
    ST_REFILL = 3'd3,
    ST_DONE   = 3'd4
  } miss_state_e;

  // Memory-side transfer type codes.
  localparam logic [2:0] RD_TYPE_LINE = 3'b100;
  localparam logic [2:0] WR_TYPE_LINE = 3'b100;
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;

  // Overlay the enabled bytes of wdata onto old.
  function automatic logic [31:0] byte_merge(input logic [31:0] wdata,
                                             input logic [31:0] old,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) begin
        res[8*b +: 8] = wdata[8*b +: 8];
      end else begin
        res[8*b +: 8] = old[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_miss_unit_beat_counter.sv
// Refill beat counter: wraps modulo the number of words per line, is cleared
// when a new miss is accepted and flags when it points at the requested bank.
module miss_beat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] req_bank_i,
  output logic [W-1:0] count_o,
  output logic         match_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins over increment; natural wrap at 2**W.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign match_o = (count_q == req_bank_i);

endmodule

// File: rtl/cache_miss_unit.sv
// Cache miss-handling unit: optional dirty-victim writeback, line refill into
// the tag/data table, store merge and completion signalling.
// Optional feature macro: MISS_EARLY_RESTART_EN -- when defined, resp_valid
// fires on the refill beat carrying the requested word instead of in DONE.
module cache_miss_unit
  import cache_pkg::*;
#(
  parameter int NUM_WAY        = 2,
  parameter int BYTES_PER_LINE = 16,
  parameter int NUM_LINE       = 256,
  parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
  parameter int INDEX_WIDTH    = $clog2(NUM_LINE),
  parameter int TAG_WIDTH      = 32 - INDEX_WIDTH - OFFSET_WIDTH,
  parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter int BITS_PER_LINE  = BYTES_PER_LINE * 8,
  parameter int BANK_NUM_WIDTH = $clog2(WORDS_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_req,
  output logic                      miss_ready,
  input  logic [31:0]               miss_addr,
  input  logic                      miss_store,
  input  logic [31:0]               miss_wdata,
  input  logic [3:0]                miss_wstrb,
  input  logic [NUM_WAY-1:0]        victim_way,
  input  logic                      victim_valid,
  input  logic                      victim_dirty,
  input  logic [TAG_WIDTH-1:0]      victim_tag,
  input  logic [BITS_PER_LINE-1:0]  victim_line,
  output logic                      miss_done,
  output logic                      resp_valid,
  output logic [31:0]               resp_data,
  output logic                      rd_req,
  output logic [2:0]                rd_type,
  output logic [31:0]               rd_addr,
  input  logic                      rd_rdy,
  input  logic                      ret_valid,
  input  logic                      ret_last,
  input  logic [31:0]               ret_data,
  output logic                      wr_req,
  output logic [2:0]                wr_type,
  output logic [31:0]               wr_addr,
  output logic [3:0]                wr_wstrb,
  output logic [BITS_PER_LINE-1:0]  wr_data,
  input  logic                      wr_rdy,
  output logic                      write,
  output logic [NUM_WAY-1:0]        write_way,
  output logic [INDEX_WIDTH-1:0]    write_index,
  output logic [BANK_NUM_WIDTH-1:0] write_bank_num,
  output logic [31:0]               write_data,
  output logic [3:0]                write_strb,
  output logic [NUM_WAY-1:0]        tag_v_write_way,
  output logic [TAG_WIDTH-1:0]      tag_write,
  output logic                      v_write,
  output logic [NUM_WAY-1:0]        d_write_way,
  output logic                      d_write
);

  miss_state_e state_q, state_d;

  // Latched request; the two byte-offset bits are never needed.
  logic [31:2]              addr_q;
  logic                     store_q;
  logic [31:0]              wdata_q;
  logic [3:0]               wstrb_q;
  logic [NUM_WAY-1:0]       way_q;
  logic [TAG_WIDTH-1:0]     vtag_q;
  logic [BITS_PER_LINE-1:0] vline_q;

  logic                      accept_s;
  logic                      beat_fire_s;
  logic [BANK_NUM_WIDTH-1:0] beat_cnt_s;
  logic                      beat_match_s;
  logic [INDEX_WIDTH-1:0]    index_s;
  logic [TAG_WIDTH-1:0]      tag_s;
  logic [BANK_NUM_WIDTH-1:0] bank_s;

  assign accept_s    = (state_q == ST_IDLE) && miss_req;
  assign beat_fire_s = (state_q == ST_REFILL) && ret_valid;
  assign index_s     = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag_s       = addr_q[31 -: TAG_WIDTH];
  assign bank_s      = addr_q[2 +: BANK_NUM_WIDTH];

  miss_beat_counter #(.W(BANK_NUM_WIDTH)) u_beat_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (accept_s),
    .en_i       (beat_fire_s),
    .req_bank_i (bank_s),
    .count_o    (beat_cnt_s),
    .match_o    (beat_match_s)
  );

  // Next-state logic; only the request/ready AND moves the handshaking states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          state_d = (victim_valid && victim_dirty) ? ST_WB : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB:     state_d = wr_rdy ? ST_RD : ST_WB;
      ST_RD:     state_d = rd_rdy ? ST_REFILL : ST_RD;
      ST_REFILL: state_d = (ret_valid && ret_last) ? ST_DONE : ST_REFILL;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the miss request and victim contents when a miss is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 30'h0;
      store_q <= 1'b0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      way_q   <= '0;
      vtag_q  <= '0;
      vline_q <= '0;
    end else if (accept_s) begin
      addr_q  <= miss_addr[31:2];
      store_q <= miss_store;
      wdata_q <= miss_wdata;
      wstrb_q <= miss_wstrb;
      way_q   <= victim_way;
      vtag_q  <= victim_tag;
      vline_q <= victim_line;
    end
  end

`ifndef MISS_EARLY_RESTART_EN
  logic [31:0] resp_data_q;

  // Hold the unmerged requested word until the response goes out in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_data_q <= 32'h0;
    end else if (beat_fire_s && beat_match_s) begin
      resp_data_q <= ret_data;
    end
  end
`endif

  // Output decode: memory requests from state, table writes per refill beat.
  always_comb begin
    miss_ready      = (state_q == ST_IDLE);
    miss_done       = (state_q == ST_DONE);
    rd_req          = 1'b0;
    rd_type         = 3'b000;
    rd_addr         = 32'h0;
    wr_req          = 1'b0;
    wr_type         = 3'b000;
    wr_addr         = 32'h0;
    wr_wstrb        = 4'h0;
    wr_data         = '0;
    write           = 1'b0;
    write_way       = '0;
    write_index     = '0;
    write_bank_num  = '0;
    write_data      = 32'h0;
    write_strb      = 4'h0;
    tag_v_write_way = '0;
    tag_write       = '0;
    v_write         = 1'b0;
    d_write_way     = '0;
    d_write         = 1'b0;
    if (state_q == ST_WB) begin
      wr_req   = 1'b1;
      wr_type  = WR_TYPE_LINE;
      wr_addr  = {vtag_q, index_s, {OFFSET_WIDTH{1'b0}}};
      wr_wstrb = 4'hf;
      wr_data  = vline_q;
    end else begin
      wr_req   = 1'b0;
    end
    if (state_q == ST_RD) begin
      rd_req  = 1'b1;
      rd_type = RD_TYPE_LINE;
      rd_addr = {addr_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    end else begin
      rd_req  = 1'b0;
    end
    if (beat_fire_s) begin
      write          = 1'b1;
      write_way      = way_q;
      write_index    = index_s;
      write_bank_num = beat_cnt_s;
      write_strb     = 4'hf;
      if (store_q && beat_match_s) begin
        write_data = byte_merge(wdata_q, ret_data, wstrb_q);
      end else begin
        write_data = ret_data;
      end
      if (ret_last) begin
        tag_v_write_way = way_q;
        tag_write       = tag_s;
        v_write         = 1'b1;
        d_write_way     = way_q;
        d_write         = store_q;
      end else begin
        v_write         = 1'b0;
      end
    end else begin
      write = 1'b0;
    end
`ifdef MISS_EARLY_RESTART_EN
    resp_valid = beat_fire_s && beat_match_s;
    resp_data  = resp_valid ? ret_data : 32'h0;
`else
    resp_valid = (state_q == ST_DONE);
    resp_data  = resp_data_q;
`endif
  end

endmodule

// File: tb/tb_cache_miss_unit.sv
// Self-checking bench for cache_miss_unit: a transaction-level reference
// model drives a per-cycle comparison, plus hand-computed end-of-test checks.
module tb_cache_miss_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         miss_req, miss_ready, miss_store;
  logic [31:0]  miss_addr, miss_wdata;
  logic [3:0]   miss_wstrb;
  logic [1:0]   victim_way;
  logic         victim_valid, victim_dirty;
  logic [19:0]  victim_tag;
  logic [127:0] victim_line;
  logic         miss_done, resp_valid;
  logic [31:0]  resp_data;
  logic         rd_req, rd_rdy;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req, wr_rdy;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         write;
  logic [1:0]   write_way;
  logic [7:0]   write_index;
  logic [1:0]   write_bank_num;
  logic [31:0]  write_data;
  logic [3:0]   write_strb;
  logic [1:0]   tag_v_write_way, d_write_way;
  logic [19:0]  tag_write;
  logic         v_write, d_write;

  cache_miss_unit dut (
    .clk(clk), .reset(reset),
    .miss_req(miss_req), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_store(miss_store), .miss_wdata(miss_wdata), .miss_wstrb(miss_wstrb),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_line(victim_line),
    .miss_done(miss_done), .resp_valid(resp_valid), .resp_data(resp_data),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .write(write), .write_way(write_way), .write_index(write_index),
    .write_bank_num(write_bank_num), .write_data(write_data), .write_strb(write_strb),
    .tag_v_write_way(tag_v_write_way), .tag_write(tag_write), .v_write(v_write),
    .d_write_way(d_write_way), .d_write(d_write)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int bank_of(input logic [31:0] a);  return int'((a >> 2) & 32'd3);   endfunction
  function automatic int index_of(input logic [31:0] a); return int'((a >> 4) & 32'd255); endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] a); return a >> 12; endfunction

  function automatic logic [31:0] merge(input logic [31:0] nw, input logic [31:0] old,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      r = r | ((strb[b] ? nw : old) & (32'hFF << (8 * b)));
    end
    return r;
  endfunction

  // ---------------- reference model: miss transaction progress ----------------
  // phase: 0 waiting for a miss, 1 writing back, 2 requesting the line,
  //        3 receiving beats, 4 completion cycle
  int           m_phase, m_beat;
  logic [31:0]  m_addr, m_wdata, m_resp;
  logic         m_store;
  logic [3:0]   m_wstrb;
  logic [1:0]   m_way;
  logic [19:0]  m_vtag;
  logic [127:0] m_line;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_beat  <= 0;
    end else begin
      case (m_phase)
        0: if (miss_req) begin
             m_addr <= miss_addr; m_store <= miss_store; m_wdata <= miss_wdata;
             m_wstrb <= miss_wstrb; m_way <= victim_way; m_vtag <= victim_tag;
             m_line <= victim_line; m_beat <= 0;
             m_phase <= (victim_valid && victim_dirty) ? 1 : 2;
           end
        1: if (wr_rdy) m_phase <= 2;
        2: if (rd_rdy) m_phase <= 3;
        3: if (ret_valid) begin
             if (m_beat == bank_of(m_addr)) m_resp <= ret_data;
             m_beat <= (m_beat + 1) % 4;
             if (ret_last) m_phase <= 4;
           end
        4: m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  // ---------------- shadow table and event records ----------------
  logic [31:0] tbl       [2][256][4];
  logic [19:0] tag_mem   [2][256];
  logic        dirty_mem [2][256];
  int writes = 0, wr_cycles = 0;
  int last_beat_cyc = 0, done_cyc = 0, resp_cyc = 0, rd_cyc = 0, wr_hs_cyc = 0;
  logic [31:0] last_wr_addr, last_rd_addr, resp_word;
  logic        exp_write, exp_rv;
  logic [31:0] exp_wdata;
  int          wsel;

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("miss_ready", miss_ready, m_phase == 0);
      chk("wr_req", wr_req, m_phase == 1);
      chk("rd_req", rd_req, m_phase == 2);
      chk("miss_done", miss_done, m_phase == 4);
      exp_write = (m_phase == 3) && ret_valid;
      chk("write", write, exp_write);
      if (m_phase == 1) begin
        chk("wr_addr", wr_addr, {m_vtag, 12'h0} | (index_of(m_addr) << 4));
        chk("wr_type", wr_type, 3'b100);
        chk("wr_wstrb", wr_wstrb, 4'hf);
        chk("wr_data", wr_data, m_line);
      end
      if (m_phase == 2) begin
        chk("rd_addr", rd_addr, m_addr & 32'hFFFF_FFF0);
        chk("rd_type", rd_type, 3'b100);
      end
      if (exp_write) begin
        exp_wdata = (m_store && m_beat == bank_of(m_addr)) ?
                    merge(m_wdata, ret_data, m_wstrb) : ret_data;
        chk("write_way", write_way, m_way);
        chk("write_index", write_index, index_of(m_addr));
        chk("write_bank_num", write_bank_num, m_beat);
        chk("write_strb", write_strb, 4'hf);
        chk("write_data", write_data, exp_wdata);
        chk("v_write", v_write, ret_last);
        if (ret_last) begin
          chk("tag_write", tag_write, tag_of(m_addr));
          chk("tag_v_write_way", tag_v_write_way, m_way);
          chk("d_write_way", d_write_way, m_way);
          chk("d_write", d_write, m_store);
        end
      end
`ifdef MISS_EARLY_RESTART_EN
      exp_rv = exp_write && (m_beat == bank_of(m_addr));
      if (exp_rv && !m_store) chk("resp_data", resp_data, ret_data);
`else
      exp_rv = (m_phase == 4);
      if (exp_rv && !m_store) chk("resp_data", resp_data, m_resp);
`endif
      chk("resp_valid", resp_valid, exp_rv);
      // event records taken from the DUT for the literal end-of-test checks
      if (write) begin
        writes++;
        wsel = write_way[1] ? 1 : 0;
        tbl[wsel][write_index][write_bank_num] = write_data;
        if (ret_last) last_beat_cyc = cyc;
      end
      if (v_write) begin
        wsel = tag_v_write_way[1] ? 1 : 0;
        tag_mem[wsel][write_index] = tag_write;
        dirty_mem[wsel][write_index] = d_write;
      end
      if (wr_req) begin
        wr_cycles++;
        last_wr_addr = wr_addr;
        if (wr_rdy) wr_hs_cyc = cyc;
      end
      if (rd_req) begin
        rd_cyc = cyc;
        last_rd_addr = rd_addr;
      end
      if (resp_valid) begin
        resp_cyc = cyc;
        resp_word = resp_data;
      end
      if (miss_done) done_cyc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [31:0] beat_data [4];
  int          beat_gap  [4];

  task automatic start_miss(input logic [31:0] a, input logic st, input logic [31:0] wd,
                            input logic [3:0] ws, input logic [1:0] way, input logic vv,
                            input logic vd, input logic [19:0] tg, input logic [127:0] ln);
    miss_addr = a; miss_store = st; miss_wdata = wd; miss_wstrb = ws;
    victim_way = way; victim_valid = vv; victim_dirty = vd;
    victim_tag = tg; victim_line = ln;
    miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
  endtask

  task automatic rd_handshake();
    rd_rdy = 1'b1;
    @(posedge clk); #1;
    rd_rdy = 1'b0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (beat_gap[i]) begin @(posedge clk); #1; end
      ret_valid = 1'b1; ret_last = (i == 3); ret_data = beat_data[i];
      @(posedge clk); #1;
      ret_valid = 1'b0; ret_last = 1'b0;
    end
  endtask

  task automatic set_beats(input logic [31:0] base, input int g0, input int g1,
                           input int g2, input int g3);
    for (int i = 0; i < 4; i++) beat_data[i] = base + i;
    beat_gap[0] = g0; beat_gap[1] = g1; beat_gap[2] = g2; beat_gap[3] = g3;
  endtask

  task automatic wait_idle();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  int wbase;

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_addr = 32'h0; miss_store = 1'b0;
    miss_wdata = 32'h0; miss_wstrb = 4'h0; victim_way = 2'b00; victim_valid = 1'b0;
    victim_dirty = 1'b0; victim_tag = 20'h0; victim_line = 128'h0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'h0; wr_rdy = 1'b0;
    #3;
    // reset state
    chk("rst miss_ready", miss_ready, 1'b1);
    chk("rst rd_req", rd_req, 1'b0);
    chk("rst wr_req", wr_req, 1'b0);
    chk("rst write", write, 1'b0);
    chk("rst miss_done", miss_done, 1'b0);
    chk("rst resp_valid", resp_valid, 1'b0);
    chk("rst rd_addr", rd_addr, 32'h0);
    chk("rst wr_addr", wr_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // 1) clean miss; both ready lines raised early, which must be harmless
    wr_rdy = 1'b1; rd_rdy = 1'b1; wr_cycles = 0;
    start_miss(32'h0000_1234, 1'b0, 32'h0, 4'h0, 2'b01, 1'b1, 1'b0, 20'h00009,
               128'h1111_2222_3333_4444_5555_6666_7777_8888);
    @(posedge clk); #1;
    rd_rdy = 1'b0; wr_rdy = 1'b0;
    set_beats(32'hA0, 0, 0, 0, 0);
    send_beats(4);
    wait_idle();
    chk("clean wr_cycles", wr_cycles, 0);
    chk("clean rd_addr", last_rd_addr, 32'h0000_1230);
    for (int i = 0; i < 4; i++) chk("clean bank", tbl[0][8'h23][i], 32'hA0 + i);
    chk("clean tag", tag_mem[0][8'h23], 20'h00001);
    chk("clean dirty", dirty_mem[0][8'h23], 1'b0);
    chk("clean done latency", done_cyc - last_beat_cyc, 1);

    // 2) dirty victim writeback with wr_rdy held low for 3 cycles;
    //    stray ret_valid during writeback must be ignored
    wr_cycles = 0;
    start_miss(32'h0000_5230, 1'b0, 32'h0, 4'h0, 2'b10, 1'b1, 1'b1, 20'h00002,
               128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    ret_valid = 1'b1; ret_data = 32'hBAD0_BAD0;
    repeat (3) @(posedge clk);
    #1 wr_rdy = 1'b1; ret_valid = 1'b0;
    @(posedge clk); #1 wr_rdy = 1'b0;
    rd_handshake();
    set_beats(32'hB0, 0, 0, 0, 0);
    send_beats(4);
    wait_idle();
    chk("dirty wr_cycles", wr_cycles, 4);
    chk("dirty wr_addr", last_wr_addr, 32'h0000_2230);
    chk("dirty rd after wr", rd_cyc - wr_hs_cyc, 1);
    chk("dirty bank0", tbl[1][8'h23][0], 32'hB0);
    chk("dirty tag", tag_mem[1][8'h23], 20'h00005);

    // 3) store miss to bank 2 with byte merge
    start_miss(32'h0000_3238, 1'b1, 32'h1111_2222, 4'b0011, 2'b01, 1'b1, 1'b0, 20'h0, 128'h0);
    rd_handshake();
    set_beats(32'hC0, 0, 0, 0, 0);
    beat_data[2] = 32'hAAAA_BBBB;
    send_beats(4);
    wait_idle();
    chk("store bank2", tbl[0][8'h23][2], 32'hAAAA_2222);
    chk("store bank1", tbl[0][8'h23][1], 32'hC1);
    chk("store dirty", dirty_mem[0][8'h23], 1'b1);
    chk("store tag", tag_mem[0][8'h23], 20'h00003);

    // 4) load to bank 1: response timing relative to completion
    start_miss(32'h0000_4434, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, 1'b1, 20'h0, 128'h0);
    rd_handshake();
    set_beats(32'hD0, 0, 0, 0, 0);
    send_beats(4);
    wait_idle();
    chk("restart resp_word", resp_word, 32'hD1);
`ifdef MISS_EARLY_RESTART_EN
    chk("restart resp lead", done_cyc - resp_cyc, 3);
`else
    chk("restart resp lead", done_cyc - resp_cyc, 0);
`endif

    // 5) gaps of 0..2 idle cycles between beats
    start_miss(32'h0000_6570, 1'b0, 32'h0, 4'h0, 2'b01, 1'b0, 1'b0, 20'h0, 128'h0);
    rd_handshake();
    set_beats(32'hE0, 1, 0, 2, 1);
    send_beats(4);
    wait_idle();
    for (int i = 0; i < 4; i++) chk("gap bank", tbl[0][8'h57][i], 32'hE0 + i);
    chk("gap done latency", done_cyc - last_beat_cyc, 1);

    // 6) reset asserted during refill after two beats
    start_miss(32'h0000_7680, 1'b0, 32'h0, 4'h0, 2'b10, 1'b0, 1'b0, 20'h0, 128'h0);
    rd_handshake();
    wbase = writes;
    set_beats(32'hF0, 0, 0, 0, 0);
    send_beats(2);
    ret_valid = 1'b1; ret_data = 32'hF2;
    #2 reset = 1'b1;
    #1;
    chk("abort write", write, 1'b0);
    chk("abort write_data", write_data, 32'h0);
    chk("abort rd_req", rd_req, 1'b0);
    chk("abort miss_done", miss_done, 1'b0);
    chk("abort resp_valid", resp_valid, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 ret_valid = 1'b0;
    chk("abort miss_ready", miss_ready, 1'b1);
    chk("abort table writes", writes - wbase, 2);
    chk("abort bank1", tbl[1][8'h68][1], 32'hF1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
